// File: rtl/ibi_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ibi_scheduler_pkg
//  Description : Shared types and constants for the IBI scheduler: FSM state
//                encoding, completion status codes, requester/address limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package ibi_scheduler_pkg;

    localparam int MAX_REQ = 8;
    localparam int ADDR_W  = 7;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_BUS    = 3'd1,
        ISSUE       = 3'd2,
        WAIT_RESULT = 3'd3,
        BACKOFF     = 3'd4,
        REPORT      = 3'd5
    } ibi_state_e;

    typedef enum logic [1:0] {
        STATUS_OK             = 2'b00,
        STATUS_NACK_EXHAUSTED = 2'b01,
        STATUS_DISABLED       = 2'b10,
        STATUS_ADDR_INVALID   = 2'b11
    } ibi_status_e;

endpackage
`default_nettype wire

// File: rtl/ibi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ibi_rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first set
//                request bit at or after the pointer, wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibi_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDW-1:0]     o_gnt_idx
);

    logic w_found;

    // Two passes: first the bits at/after the pointer, then the wrap-around.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && i_req[j] && (j >= int'(i_ptr))) begin
                w_found   = 1'b1;
                o_gnt[j]  = 1'b1;
                o_gnt_idx = IDW'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && i_req[j]) begin
                w_found   = 1'b1;
                o_gnt[j]  = 1'b1;
                o_gnt_idx = IDW'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ibi_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ibi_scheduler
//  Description : Arbitrates IBI requests from several target personalities,
//                sequences one IBI at a time onto the bus FSM, retries NACKs
//                up to the configured count and reports completion status.
//                Optional macro I3C_IBI_BACKOFF_EN inserts an idle backoff
//                period of BACKOFF_CYCLES after each retryable NACK.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibi_scheduler
    import ibi_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int BACKOFF_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ibi_enable_i,
    input  logic [2:0]                ibi_retry_num_i,
    input  logic                      bus_available_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ-1:0]        addr_valid_i,
    input  logic [NUM_REQ*8-1:0]      mdb_i,
    output logic                      ibi_start_o,
    output logic [ADDR_W-1:0]         ibi_addr_o,
    output logic [7:0]                ibi_mdb_o,
    input  logic                      ibi_done_i,
    input  logic                      ibi_acked_i,
    input  logic                      ibi_lost_arb_i,
    output logic                      done_o,
    output logic [IDW-1:0]            done_id_o,
    output logic [1:0]                done_status_o,
    output logic                      busy_o,
    output logic [2:0]                retry_cnt_o
);

    if (NUM_REQ < 1 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("ibi_scheduler: NUM_REQ out of range");
    end
    if (BACKOFF_CYCLES < 1 || BACKOFF_CYCLES > 65535) begin : g_bad_backoff
        $error("ibi_scheduler: BACKOFF_CYCLES out of range");
    end

    ibi_state_e         r_state,  w_state_nxt;
    ibi_status_e        r_status, w_status_nxt;
    logic               r_pend,   w_pend_nxt;
    logic               w_grab;
    logic [IDW-1:0]     r_id;
    logic [IDW-1:0]     r_ptr,    w_ptr_nxt;
    logic [IDW-1:0]     w_gnt_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_mdb;
    logic               r_valid;
    logic [2:0]         r_retry_num;
    logic [2:0]         r_retry_cnt, w_retry_nxt;

`ifdef I3C_IBI_BACKOFF_EN
    localparam logic [15:0] c_bo_last = 16'(BACKOFF_CYCLES - 1);
    logic [15:0] r_bo_cnt;

    // Backoff counter restarts every time BACKOFF is entered.
    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state != BACKOFF)) r_bo_cnt <= '0;
        else                               r_bo_cnt <= r_bo_cnt + 16'd1;
    end
`endif

    ibi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .i_req     (req_i),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Request context (held for the whole request), retry counter, RR pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend      <= 1'b0;
            r_status    <= STATUS_OK;
            r_retry_cnt <= '0;
            r_ptr       <= '0;
            r_id        <= '0;
            r_addr      <= '0;
            r_mdb       <= '0;
            r_valid     <= 1'b0;
            r_retry_num <= '0;
        end else begin
            r_pend      <= w_pend_nxt;
            r_status    <= w_status_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_ptr       <= w_ptr_nxt;
            if (w_grab) begin
                r_id        <= w_gnt_idx;
                r_addr      <= addr_i[w_gnt_idx*ADDR_W +: ADDR_W];
                r_mdb       <= mdb_i[w_gnt_idx*8 +: 8];
                r_valid     <= addr_valid_i[w_gnt_idx];
                r_retry_num <= ibi_retry_num_i;
            end
        end
    end

    // Next-state, status, retry and pointer decisions plus Moore outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_status_nxt  = r_status;
        w_retry_nxt   = r_retry_cnt;
        w_ptr_nxt     = r_ptr;
        w_pend_nxt    = r_pend;
        w_grab        = 1'b0;
        ibi_start_o   = (r_state == ISSUE);
        ibi_addr_o    = r_addr;
        ibi_mdb_o     = r_mdb;
        done_o        = (r_state == REPORT);
        done_id_o     = (r_state == REPORT) ? r_id : '0;
        done_status_o = (r_state == REPORT) ? r_status : 2'b00;
        busy_o        = (r_state != IDLE);
        retry_cnt_o   = r_retry_cnt;

        case (r_state)
            IDLE: begin
                // Grant is captured first; the following cycle qualifies it.
                if (r_pend) begin
                    w_pend_nxt = 1'b0;
                    if (!r_valid) begin
                        w_state_nxt  = REPORT;
                        w_status_nxt = STATUS_ADDR_INVALID;
                    end else begin
                        w_state_nxt = WAIT_BUS;
                    end
                end else if (ibi_enable_i && (|w_gnt)) begin
                    w_grab     = 1'b1;
                    w_pend_nxt = 1'b1;
                end
            end
            WAIT_BUS: begin
                if (!ibi_enable_i) begin
                    w_state_nxt  = REPORT;
                    w_status_nxt = STATUS_DISABLED;
                end else if (bus_available_i) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT_RESULT;
            end
            WAIT_RESULT: begin
                // The attempt in flight always finishes; enable is only
                // consulted once a NACK decides whether to retry.
                if (ibi_done_i) begin
                    if (ibi_acked_i) begin
                        w_state_nxt  = REPORT;
                        w_status_nxt = STATUS_OK;
                    end else if (ibi_lost_arb_i) begin
                        w_state_nxt = WAIT_BUS;
                    end else if (!ibi_enable_i) begin
                        w_state_nxt  = REPORT;
                        w_status_nxt = STATUS_DISABLED;
                    end else if (r_retry_cnt == r_retry_num) begin
                        w_state_nxt  = REPORT;
                        w_status_nxt = STATUS_NACK_EXHAUSTED;
                    end else begin
                        w_retry_nxt = (r_retry_cnt == 3'd7) ? 3'd7 : r_retry_cnt + 3'd1;
`ifdef I3C_IBI_BACKOFF_EN
                        w_state_nxt = BACKOFF;
`else
                        w_state_nxt = WAIT_BUS;
`endif
                    end
                end
            end
            BACKOFF: begin
`ifdef I3C_IBI_BACKOFF_EN
                if (!ibi_enable_i) begin
                    w_state_nxt  = REPORT;
                    w_status_nxt = STATUS_DISABLED;
                end else if (r_bo_cnt == c_bo_last) begin
                    w_state_nxt = WAIT_BUS;
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            REPORT: begin
                w_ptr_nxt   = IDW'((int'(r_id) + 1) % NUM_REQ);
                w_retry_nxt = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ibi_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ibi_scheduler
//  Description : Self-checking bench for ibi_scheduler. Table of request
//                scenarios with a scripted bus-FSM responder; expected
//                completions go through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ibi_scheduler;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          ibi_enable_i;
    logic [2:0]    ibi_retry_num_i;
    logic          bus_available_i;
    logic [N-1:0]  req_i;
    logic [N*7-1:0] addr_i;
    logic [N-1:0]  addr_valid_i;
    logic [N*8-1:0] mdb_i;
    logic          ibi_start_o;
    logic [6:0]    ibi_addr_o;
    logic [7:0]    ibi_mdb_o;
    logic          ibi_done_i;
    logic          ibi_acked_i;
    logic          ibi_lost_arb_i;
    logic          done_o;
    logic [0:0]    done_id_o;
    logic [1:0]    done_status_o;
    logic          busy_o;
    logic [2:0]    retry_cnt_o;

    always #5 clk = ~clk;

    ibi_scheduler #(.NUM_REQ(N), .BACKOFF_CYCLES(16)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .ibi_enable_i    (ibi_enable_i),
        .ibi_retry_num_i (ibi_retry_num_i),
        .bus_available_i (bus_available_i),
        .req_i           (req_i),
        .addr_i          (addr_i),
        .addr_valid_i    (addr_valid_i),
        .mdb_i           (mdb_i),
        .ibi_start_o     (ibi_start_o),
        .ibi_addr_o      (ibi_addr_o),
        .ibi_mdb_o       (ibi_mdb_o),
        .ibi_done_i      (ibi_done_i),
        .ibi_acked_i     (ibi_acked_i),
        .ibi_lost_arb_i  (ibi_lost_arb_i),
        .done_o          (done_o),
        .done_id_o       (done_id_o),
        .done_status_o   (done_status_o),
        .busy_o          (busy_o),
        .retry_cnt_o     (retry_cnt_o)
    );

    // mode: 0 normal, 1 enable dropped in WAIT_BUS, 2 enable dropped in WAIT_RESULT
    typedef struct {
        logic [1:0] req;
        logic [1:0] valid;
        logic [6:0] a0;
        logic [6:0] a1;
        logic [2:0] rnum;
        int         nack_n;
        int         lost_n;
        int         mode;
        int         e_id;
        logic [1:0] e_st;
        logic [2:0] e_rc;
        int         e_starts;
    } vec_t;

    typedef struct {
        int         id;
        logic [1:0] st;
        logic [2:0] rc;
        int         starts;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v, input int tag);
        exp_t e;
        exp_t g;
        int   starts;
        int   timer;
        int   first;
        int   last_nack;
        int   k;
        bit   got;
        starts = 0; timer = 0; first = -1; last_nack = -1; got = 0;
        e.id = v.e_id; e.st = v.e_st; e.rc = v.e_rc; e.starts = v.e_starts;
        sb.push_back(e);
        @(negedge clk);
        req_i           = v.req;
        addr_valid_i    = v.valid;
        addr_i          = {v.a1, v.a0};
        ibi_retry_num_i = v.rnum;
        bus_available_i = (v.mode != 1);
        ibi_enable_i    = 1'b1;
        for (int cyc = 0; cyc < 600 && !got; cyc++) begin
            @(negedge clk);
            ibi_done_i = 1'b0; ibi_acked_i = 1'b0; ibi_lost_arb_i = 1'b0;
            if (v.mode == 1 && cyc == 1) begin
                ibi_done_i = 1'b1; ibi_acked_i = 1'b1;   // stray done, must be ignored
            end
            if (v.mode == 1 && cyc == 3) ibi_enable_i = 1'b0;
            if (ibi_start_o) begin
                if (first < 0) begin
                    first = cyc;
                    chk($sformatf("v%0d start_latency", tag), cyc + 1, 3);
                end
                if (last_nack >= 0) begin
`ifdef I3C_IBI_BACKOFF_EN
                    chk($sformatf("v%0d backoff_gap_ge18", tag), (cyc - last_nack) >= 18, 1);
`else
                    chk($sformatf("v%0d retry_gap", tag), cyc - last_nack, 2);
`endif
                    last_nack = -1;
                end
                chk($sformatf("v%0d start_addr", tag), ibi_addr_o, (v.e_id != 0) ? v.a1 : v.a0);
                chk($sformatf("v%0d start_mdb", tag), ibi_mdb_o, (v.e_id != 0) ? 8'hB1 : 8'hA0);
                timer = 2;
                starts++;
            end else if (timer > 0) begin
                timer--;
                if (timer == 1 && v.mode == 2) ibi_enable_i = 1'b0;
                if (timer == 0) begin
                    k = starts - 1;
                    ibi_done_i = 1'b1;
                    if (k < v.lost_n) ibi_lost_arb_i = 1'b1;
                    else if (v.mode != 2 && (k - v.lost_n) >= v.nack_n) ibi_acked_i = 1'b1;
                    else last_nack = cyc;
                end
            end
            if (done_o) begin
                got = 1;
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d unexpected_done", tag), 1, 0);
                end else begin
                    g = sb.pop_front();
                    chk($sformatf("v%0d done_id", tag), done_id_o, g.id);
                    chk($sformatf("v%0d done_status", tag), done_status_o, g.st);
                    chk($sformatf("v%0d retry_cnt", tag), retry_cnt_o, g.rc);
                    chk($sformatf("v%0d start_count", tag), starts, g.starts);
                    chk($sformatf("v%0d busy_at_done", tag), busy_o, 1);
                end
            end
        end
        if (!got) chk($sformatf("v%0d done_timeout", tag), 0, 1);
        ibi_done_i = 1'b0; ibi_acked_i = 1'b0; ibi_lost_arb_i = 1'b0;
        ibi_enable_i = 1'b1; bus_available_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t h;
        bit   seen;
        //          req    valid  a0     a1     rnum  nk lo md id st     rc    starts
        vt[0]  = '{2'b01, 2'b11, 7'h5A, 7'h21, 3'd0, 0, 0, 0, 0, 2'b00, 3'd0, 1};
        vt[1]  = '{2'b01, 2'b11, 7'h12, 7'h21, 3'd2, 3, 0, 0, 0, 2'b01, 3'd2, 3};
        vt[2]  = '{2'b11, 2'b11, 7'h13, 7'h23, 3'd1, 0, 0, 0, 1, 2'b00, 3'd0, 1};
        vt[3]  = '{2'b11, 2'b11, 7'h14, 7'h24, 3'd1, 0, 0, 0, 0, 2'b00, 3'd0, 1};
        vt[4]  = '{2'b11, 2'b11, 7'h15, 7'h25, 3'd1, 1, 0, 0, 1, 2'b00, 3'd1, 2};
        vt[5]  = '{2'b11, 2'b11, 7'h16, 7'h26, 3'd1, 0, 0, 0, 0, 2'b00, 3'd0, 1};
        vt[6]  = '{2'b10, 2'b01, 7'h17, 7'h27, 3'd1, 0, 0, 0, 1, 2'b11, 3'd0, 0};
        vt[7]  = '{2'b01, 2'b11, 7'h18, 7'h28, 3'd1, 0, 0, 1, 0, 2'b10, 3'd0, 0};
        vt[8]  = '{2'b01, 2'b11, 7'h19, 7'h29, 3'd3, 1, 0, 2, 0, 2'b10, 3'd0, 1};
        vt[9]  = '{2'b01, 2'b11, 7'h1A, 7'h2A, 3'd1, 1, 2, 0, 0, 2'b00, 3'd1, 4};
        vt[10] = '{2'b10, 2'b11, 7'h1B, 7'h33, 3'd7, 7, 0, 0, 1, 2'b00, 3'd7, 8};
        vt[11] = '{2'b01, 2'b11, 7'h1C, 7'h2C, 3'd7, 8, 0, 0, 0, 2'b01, 3'd7, 8};
        vt[12] = '{2'b01, 2'b11, 7'h1D, 7'h2D, 3'd0, 1, 0, 0, 0, 2'b01, 3'd0, 1};

        rst_i = 1'b1; ibi_enable_i = 1'b1; ibi_retry_num_i = 3'd0; bus_available_i = 1'b1;
        req_i = '0; addr_i = '0; addr_valid_i = '0; mdb_i = {8'hB1, 8'hA0};
        ibi_done_i = 1'b0; ibi_acked_i = 1'b0; ibi_lost_arb_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {busy_o, done_o, ibi_start_o, retry_cnt_o, ibi_addr_o, ibi_mdb_o, done_id_o, done_status_o}, 0);
        rst_i = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vt[i], i);

        // Reset while an attempt is in flight: no completion, back to idle, pointer 0.
        @(negedge clk);
        req_i = 2'b01; addr_valid_i = 2'b11; addr_i = {7'h41, 7'h40}; ibi_retry_num_i = 3'd1;
        seen = 0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (ibi_start_o) seen = 1;
        end
        chk("midop_start_seen", seen, 1);
        rst_i = 1'b1; req_i = '0;
        @(negedge clk);
        chk("midop_reset_outputs", {busy_o, done_o, ibi_start_o, retry_cnt_o, ibi_addr_o}, 0);
        rst_i = 1'b0;
        h = '{2'b11, 2'b11, 7'h50, 7'h51, 3'd0, 0, 0, 0, 0, 2'b00, 3'd0, 1};
        run_vec(h, 13);

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
